// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction fetch stage in front of the IF/ID register.
// It owns the fetch PC and issues pipelined requests to instruction memory.
// Returned words are buffered in an in-order queue and presented as {inst, pc, valid}.
// A branch redirect flushes the queue. Responses still in flight are then counted
// off in the FLUSH state and dropped.
// Optional feature: define FETCH_PERF_CNT_EN to add the perf_fetched and
// perf_starve counter outputs. When it is undefined, those ports do not exist.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [63:0] if_pc,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_starve
`endif
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t        state_reg;
    logic [63:0]   pc_reg;
    logic [CW-1:0] out_reg;        // requests issued, response not yet seen
    logic [CW-1:0] count_reg;      // words sitting in the instruction queue
    logic [CW-1:0] discard_reg;    // stale responses still to be dropped
    logic [PW-1:0] q_head_reg, q_tail_reg;
    logic [PW-1:0] t_head_reg, t_tail_reg;

    // Instruction queue and the PC tag queue that travels with each request
    logic [31:0]   q_inst_mem [DEPTH];
    logic [63:0]   q_pc_mem   [DEPTH];
    logic [63:0]   tag_pc_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] out_next;
    logic [63:0]   redirect_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign imem_addr       = pc_reg;
    assign redirect_target = redirect_pc & ~64'h3;

    // Request gating, handshake events and the next outstanding count
    always_comb begin
        occupancy = {1'b0, out_reg} + {1'b0, count_reg};
        imem_req  = arst_n && (state_reg == ST_RUN) && !redirect_valid
                    && (occupancy < DEPTH_W);
        issue     = imem_req && imem_gnt;
        // Responses are only kept in RUN; during FLUSH or a redirect they are stale
        push      = imem_rvalid && (state_reg == ST_RUN) && !redirect_valid;
        pop       = if_valid && !stall && !redirect_valid;
        out_next  = out_reg + CW'(issue) - CW'(imem_rvalid);
    end

    // Head of queue drives IF/ID; a NOP bubble with pc 0 when empty
    always_comb begin
        if_valid = (count_reg != '0);
        if_inst  = NOP_INST;
        if_pc    = 64'h0;
        if (if_valid) begin
            if_inst = q_inst_mem[q_head_reg];
            if_pc   = q_pc_mem[q_head_reg];
        end
    end

    // Control state: PC, counters, pointers and RUN/FLUSH sequencing
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg   <= ST_RUN;
            pc_reg      <= RESET_PC;
            out_reg     <= '0;
            count_reg   <= '0;
            discard_reg <= '0;
            q_head_reg  <= '0;
            q_tail_reg  <= '0;
            t_head_reg  <= '0;
            t_tail_reg  <= '0;
        end else if (redirect_valid) begin
            // Everything in flight becomes stale; the tag queue is emptied with it
            pc_reg      <= redirect_target;
            count_reg   <= '0;
            q_head_reg  <= '0;
            q_tail_reg  <= '0;
            t_head_reg  <= t_tail_reg;
            out_reg     <= out_next;
            discard_reg <= out_next;
            state_reg   <= (out_next != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            out_reg <= out_next;
            if (issue) begin
                pc_reg     <= pc_reg + 64'd4;
                t_tail_reg <= ptr_inc(t_tail_reg);
            end
            case (state_reg)
                ST_RUN: begin
                    if (imem_rvalid) t_head_reg <= ptr_inc(t_head_reg);
                    if (push)        q_tail_reg <= ptr_inc(q_tail_reg);
                    if (pop)         q_head_reg <= ptr_inc(q_head_reg);
                    count_reg <= count_reg + CW'(push) - CW'(pop);
                end
                ST_FLUSH: begin
                    if (imem_rvalid) begin
                        discard_reg <= discard_reg - CW'(1);
                        if (discard_reg == CW'(1)) state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    // Queue storage: tag written at issue, word and its tag written at response
    always_ff @(posedge clk) begin
        if (issue) tag_pc_mem[t_tail_reg] <= pc_reg;
        if (push) begin
            q_inst_mem[q_tail_reg] <= imem_rdata;
            q_pc_mem[q_tail_reg]   <= tag_pc_mem[t_head_reg];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_starve_reg;

    // Words consumed by IF/ID and cycles IF/ID wanted a word but had none
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            perf_fetched_reg <= 32'h0;
            perf_starve_reg  <= 32'h0;
        end else begin
            if (if_valid && !stall)  perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (!if_valid && !stall) perf_starve_reg  <= perf_starve_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_starve  = perf_starve_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit -- randomized scoreboard bench for if_fetch_unit.
// The bench memory answers in order after a random latency.
// The reference model keeps the list of PCs fetched since the last redirect.
// It also counts stale in-flight responses.
module tb_if_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_starve;
    int unsigned m_fetched;
    int unsigned m_starve;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .arst_n(arst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetched(perf_fetched), .perf_starve(perf_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_t;

    mem_t        mem_q[$];       // requests accepted by the bench memory
    logic [63:0] exp_q[$];       // live PCs since last redirect, oldest first
    int          stale_cnt;
    int          returned_cnt;   // live words already returned, not yet consumed
    logic [63:0] model_pc;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        auto_drive = 1'b0;
    int          stall_pct = 0, gnt_pct = 100, redir_pct = 0, rsp_pct = 100;
    int          lat_min = 1, lat_max = 1;
    logic        exp_req;
    logic [63:0] exp_pc;
    mem_t        new_req;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: event not seen within cycle budget (cycle %0d)", name, cyc);
    endtask

    // Stimulus and memory responder, driven just after the rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (auto_drive && arst_n) begin
            stall          = ($urandom_range(0, 99) < stall_pct);
            imem_gnt       = ($urandom_range(0, 99) < gnt_pct);
            redirect_valid = ($urandom_range(0, 99) < redir_pct);
            if (redirect_valid) begin
                if ($urandom_range(0, 3) == 0) redirect_pc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
                else                           redirect_pc = {$urandom, $urandom};
            end
        end
        if (arst_n && mem_q.size() > 0 && mem_q[0].due <= cyc
            && $urandom_range(0, 99) < rsp_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = inst_of(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    end

    // Monitor and scoreboard, sampling on the falling edge
    always @(negedge clk) begin
        if (!arst_n) begin
            mem_q.delete();
            exp_q.delete();
            stale_cnt    = 0;
            returned_cnt = 0;
            model_pc     = RESET_PC;
`ifdef FETCH_PERF_CNT_EN
            m_fetched = 0;
            m_starve  = 0;
`endif
        end else begin
            exp_req = !redirect_valid && (stale_cnt == 0) && (exp_q.size() < DEPTH);
            check("imem_req", 64'(imem_req), 64'(exp_req));
            if (imem_req) check("imem_addr", imem_addr, model_pc);
            check("if_valid", 64'(if_valid), 64'(returned_cnt > 0));
`ifdef FETCH_PERF_CNT_EN
            if (if_valid && !stall)  m_fetched++;
            if (!if_valid && !stall) m_starve++;
`endif
            if (!if_valid) begin
                check("if_inst_empty", 64'(if_inst), 64'(NOP));
                check("if_pc_empty", if_pc, 64'h0);
            end else if (!stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_order: actual pc %h popped, required no word", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    check("if_pc", if_pc, exp_pc);
                    check("if_inst", 64'(if_inst), 64'(inst_of(exp_pc)));
                    if (returned_cnt > 0) returned_cnt--;
                end
            end
            if (imem_req && imem_gnt) begin
                new_req.addr = imem_addr;
                new_req.due  = cyc + $urandom_range(lat_min, lat_max);
                mem_q.push_back(new_req);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 64'd4;
            end
            if (imem_rvalid) begin
                if (mem_q.size() > 0) void'(mem_q.pop_front());
                if (!redirect_valid) begin
                    if (stale_cnt > 0) stale_cnt--;
                    else               returned_cnt++;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                returned_cnt = 0;
                stale_cnt    = mem_q.size();
                model_pc     = redirect_pc & ~64'h3;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [63:0] hold_addr;
        arst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0; imem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'h0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_if_valid", 64'(if_valid), 64'h0);
        check("rst_if_inst", 64'(if_inst), 64'(NOP));
        check("rst_if_pc", if_pc, 64'h0);

        // Stall from reset release: two issues, then the request drops and the head is held
        stall = 1'b1; imem_gnt = 1'b1;
        @(posedge clk); #2; arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_req_drop", 64'(imem_req), 64'h0);
        check("stall_head_valid", 64'(if_valid), 64'h1);
        check("stall_head_pc", if_pc, RESET_PC);
        @(posedge clk); #1; stall = 1'b0;
        repeat (12) @(posedge clk);

        // Redirect with two requests outstanding and no response that cycle
        #1; lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_q.size() == 2 && !imem_rvalid) found = 1'b1;
        end
        if (!found) timeout_fail("redir_setup");
        redirect_valid = 1'b1; redirect_pc = 64'h1002;
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_req_low", 64'(imem_req), 64'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        if (found) check("redir_first_addr", imem_addr, 64'h1000);
        else       timeout_fail("redir_first_addr");
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid) begin found = 1'b1; break; end
        end
        if (found) check("redir_first_pc", if_pc, 64'h1000);
        else       timeout_fail("redir_first_pc");

        // Redirect in the same cycle as a response
        @(posedge clk); #1; lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (imem_rvalid) found = 1'b1;
        end
        if (!found) timeout_fail("redir_rvalid_setup");
        redirect_valid = 1'b1; redirect_pc = 64'h3000;
        @(posedge clk); #1; redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid) begin found = 1'b1; break; end
        end
        if (found) check("redir_rvalid_pc", if_pc, 64'h3000);
        else       timeout_fail("redir_rvalid_pc");

        // Grant withheld: request and address must stay put
        @(posedge clk); #1; imem_gnt = 1'b0;
        repeat (6) @(negedge clk);
        check("gnt_low_req", 64'(imem_req), 64'h1);
        hold_addr = imem_addr;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gnt_low_req_hold", 64'(imem_req), 64'h1);
            check("gnt_low_addr_hold", imem_addr, hold_addr);
        end

        // PC wrap past the top of the address space
        @(posedge clk); #1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; imem_gnt = 1'b1;
        @(posedge clk); #1; redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin found = 1'b1; break; end
        end
        if (found) check("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        else       timeout_fail("wrap_top_addr");
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin found = 1'b1; break; end
        end
        if (found) check("wrap_zero_addr", imem_addr, 64'h0);
        else       timeout_fail("wrap_zero_addr");

        // Randomized traffic against the scoreboard
        @(posedge clk); #1;
        lat_min = 1; lat_max = 4; rsp_pct = 75; stall_pct = 30; gnt_pct = 70; redir_pct = 4;
        auto_drive = 1'b1;
        repeat (3000) @(posedge clk);

        // Asynchronous reset while flushing
        #1; auto_drive = 1'b0; stall = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b0;
        rsp_pct = 100; lat_min = 4; lat_max = 4;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (mem_q.size() > 0 && !imem_rvalid && stale_cnt == 0 && mem_q[0].due > cyc + 1)
                found = 1'b1;
        end
        if (!found) timeout_fail("flush_reset_setup");
        redirect_valid = 1'b1; redirect_pc = 64'h5000;
        @(posedge clk); #1; redirect_valid = 1'b0;
        #2; arst_n = 1'b0;
        #1;
        check("arst_imem_req", 64'(imem_req), 64'h0);
        check("arst_imem_addr", imem_addr, RESET_PC);
        check("arst_if_valid", 64'(if_valid), 64'h0);
        check("arst_if_inst", 64'(if_inst), 64'(NOP));
        check("arst_if_pc", if_pc, 64'h0);
        repeat (2) @(posedge clk);
        #2; arst_n = 1'b1;
        @(negedge clk);
        check("restart_req", 64'(imem_req), 64'h1);
        check("restart_addr", imem_addr, RESET_PC);
        repeat (20) @(posedge clk);
`ifdef FETCH_PERF_CNT_EN
        #3;
        check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("perf_starve", 64'(perf_starve), 64'(m_starve));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
